// File: rtl/note_scheduler_pkg.sv
// Shared lane, state and sprite geometry definitions for the note scheduler and the
// sprite modules it drives.
package note_scheduler_pkg;

    localparam int NUM_LANES = 5;

    typedef enum logic [2:0] {GREEN, RED, YELLOW, BLUE, ORANGE} lane_e;

    typedef enum logic [1:0] {IDLE, GAP, ARMED, FIRE} state_t;

    // Packed {orange..green}, matching the lane_y_pos ordering.
    localparam logic [NUM_LANES-1:0][9:0] LANE_X_POS =
        {10'd480, 10'd400, 10'd320, 10'd240, 10'd160};

    localparam logic [9:0] Y_STEP = 10'd8;
    localparam logic [9:0] Y_MAX  = 10'd480;

    function automatic logic [2:0] lane_count(input logic [NUM_LANES-1:0] v);
        lane_count = 3'd0;
        for (int i = 0; i < NUM_LANES; i++)
            lane_count = lane_count + 3'(v[i]);
    endfunction

endpackage

// File: rtl/note_scheduler_if.sv
// Frame-side bus between the game logic / sprites and the note scheduler.
interface note_scheduler_if;

    logic                                   frame_clk;
    logic                                   enable;
    logic [7:0]                             density;
    logic [note_scheduler_pkg::NUM_LANES*10-1:0] lane_y_pos;
    logic [note_scheduler_pkg::NUM_LANES-1:0]    spawn;
    logic [2:0]                             active_count;
    logic [15:0]                            notes_spawned;

    modport slave (
        input  frame_clk, enable, density, lane_y_pos,
        output spawn, active_count, notes_spawned
    );

    modport master (
        output frame_clk, enable, density, lane_y_pos,
        input  spawn, active_count, notes_spawned
    );

endinterface

// File: rtl/note_scheduler_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11), stepping once per adv pulse.
module lfsr16 (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv)
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge Clk) begin
        if (Reset) lfsr_q <= seed;
        else       lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule

// File: rtl/note_scheduler.sv
// Decides on frame edges when and in which lane a falling note is launched, honouring
// minimum spacing, a cap on simultaneous notes and a tunable density.
//
//   state | meaning
//   IDLE  | game stopped, no launches
//   GAP   | counting down the minimum spacing after a launch or start
//   ARMED | rolling the LFSR each frame for a launch
//   FIRE  | spawn held for the one frame the sprite samples it
module note_scheduler
    import note_scheduler_pkg::*;
#(
    parameter int          MIN_GAP_FRAMES = 20,
    parameter int          MAX_ACTIVE     = 3,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic            Clk,
    input  logic            Reset,
    note_scheduler_if.slave bus
);

    localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP_FRAMES - 1);

    state_t               state_q, state_d;
    logic [7:0]           gap_q, gap_d;
    logic [NUM_LANES-1:0] spawn_q, spawn_d, shadow_q, shadow_d;
    logic [NUM_LANES-1:0] busy, pick_onehot;
    logic [15:0]          count_q, count_d, lfsr;
    logic                 frame_dly_q, frame_edge_q, frame_edge_d;
    logic [2:0]           active, cand;
    logic                 fire_ok;

    lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .adv   (frame_edge_q),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    // Same delay + rising-edge pair as the sprites so both act on the same cycle.
    assign frame_edge_d = bus.frame_clk & ~frame_dly_q;

    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_LANES; i++)
            busy[i] = (bus.lane_y_pos[i*10 +: 10] != 10'd0) | shadow_q[i];
    end

    assign active = lane_count(busy);
    assign cand   = (lfsr[2:0] >= 3'(NUM_LANES)) ? lfsr[2:0] - 3'(NUM_LANES) : lfsr[2:0];

    // Scan from the highest offset down so the nearest free lane after cand wins.
    always_comb begin
        logic [3:0] sum;
        sum         = 4'd0;
        pick_onehot = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            sum = {1'b0, cand} + 4'(k);
            if (sum >= 4'(NUM_LANES)) sum = sum - 4'(NUM_LANES);
            if (!busy[sum[2:0]]) begin
                pick_onehot             = '0;
                pick_onehot[sum[2:0]]   = 1'b1;
            end
        end
    end

    assign fire_ok = (lfsr[15:8] < bus.density) && (int'(active) < MAX_ACTIVE) &&
                     (busy != '1);

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        spawn_d  = spawn_q;
        shadow_d = shadow_q;
        count_d  = count_q;

        if (frame_edge_q)
            shadow_d = (state_q == FIRE) ? spawn_q : '0;

        if (!bus.enable) begin
            state_d = IDLE;
            spawn_d = '0;
            gap_d   = 8'd0;
        end else if (frame_edge_q) begin
            case (state_q)
                IDLE: begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end
                GAP: begin
                    if (gap_q <= 8'd1) begin
                        gap_d   = 8'd0;
                        state_d = ARMED;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
                ARMED: begin
                    if (fire_ok) begin
                        spawn_d = pick_onehot;
                        count_d = count_q + 16'd1;
                        state_d = FIRE;
                    end
                end
                FIRE: begin
                    spawn_d = '0;
                    gap_d   = GAP_LOAD;
                    state_d = GAP;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            gap_q        <= 8'd0;
            spawn_q      <= '0;
            shadow_q     <= '0;
            count_q      <= 16'd0;
            frame_dly_q  <= 1'b0;
            frame_edge_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            spawn_q      <= spawn_d;
            shadow_q     <= shadow_d;
            count_q      <= count_d;
            frame_dly_q  <= bus.frame_clk;
            frame_edge_q <= frame_edge_d;
        end
    end

    assign bus.spawn         = spawn_q;
    assign bus.active_count  = active;
    assign bus.notes_spawned = count_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed frame sequences with a spawn scoreboard, then a
// closed loop against simple falling-sprite models.
module tb_note_scheduler;
    import note_scheduler_pkg::*;

    typedef struct packed {
        logic [4:0]  spawn;
        logic [15:0] count;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  y [5];
    exp_t        sb_q [$];
    int          checks = 0;
    int          failures = 0;
    bit          sb_on = 1'b1;
    bit          loop_mode = 1'b0;
    logic [15:0] lfsr_m = 16'hACE1;
    int          exp_cnt = 0;
    int          frame_no = 0;
    int          last_launch = -1000;
    int          launches = 0;
    logic [4:0]  prev_spawn = '0;
    bit          fired;

    note_scheduler_if bus ();

    note_scheduler #(
        .MIN_GAP_FRAMES (20),
        .MAX_ACTIVE     (3),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    always_comb bus.lane_y_pos = {y[4], y[3], y[2], y[1], y[0]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_spawn <= '0;
        end else begin
            if (sb_on && bus.spawn != 5'd0 && prev_spawn == 5'd0) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_spawn actual=%b required=none at %0t", bus.spawn, $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("spawn_lane", 32'(bus.spawn), 32'(e.spawn));
                    check("notes_at_spawn", 32'(bus.notes_spawned), 32'(e.count));
                end
            end
            prev_spawn <= bus.spawn;
        end
    end

    task automatic sprite_step();
        if (bus.spawn != 5'd0)
            check("spawn_onehot", $countones(bus.spawn), 1);
        for (int i = 0; i < 5; i++) begin
            if (y[i] != 10'd0) begin
                if (bus.spawn[i]) check("spawn_into_busy_lane", 32'(i), 32'hFF);
                y[i] = (y[i] + Y_STEP >= Y_MAX) ? 10'd0 : y[i] + Y_STEP;
            end else if (bus.spawn[i]) begin
                check("launch_gap_ge_20", 32'((frame_no - last_launch) >= 20), 1);
                y[i]        = Y_STEP;
                launches++;
                last_launch = frame_no;
            end
        end
    endtask

    // One frame strobe; when armed, predict the decision the scheduler must take on it.
    task automatic frame(input bit armed, output bit did_fire);
        logic [4:0] busy;
        int cand, pick;
        did_fire = 1'b0;
        busy = '0;
        for (int i = 0; i < 5; i++) busy[i] = (y[i] != 10'd0);
        if (armed && lfsr_m[15:8] < bus.density && $countones(busy) < 3 && busy != 5'h1F) begin
            cand = int'(lfsr_m[2:0]) % 5;
            pick = -1;
            for (int k = 0; k < 5; k++)
                if (pick < 0 && !busy[(cand + k) % 5]) pick = (cand + k) % 5;
            exp_cnt++;
            sb_q.push_back('{spawn: 5'(1 << pick), count: 16'(exp_cnt)});
            did_fire = 1'b1;
        end
        frame_no++;
        if (loop_mode) sprite_step();
        bus.frame_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.frame_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        lfsr_m = lfsr_next(lfsr_m);
    endtask

    task automatic do_reset();
        bus.frame_clk = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        lfsr_m  = 16'hACE1;
        exp_cnt = 0;
    endtask

    task automatic gap_then_fire(input string tag);
        bit f;
        f = 1'b0;
        for (int k = 0; k < 20; k++) frame(1'b0, f);
        f = 1'b0;
        for (int k = 0; k < 8 && !f; k++) frame(1'b1, f);
        check({tag, "_notes"}, 32'(bus.notes_spawned), 32'(exp_cnt));
    endtask

    initial begin
        bit f;
        bus.frame_clk = 1'b0;
        bus.enable    = 1'b0;
        bus.density   = 8'd0;
        for (int i = 0; i < 5; i++) y[i] = 10'd0;
        y[1] = 10'd5;
        do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_spawn", 32'(bus.spawn), 0);
        check("reset_notes", 32'(bus.notes_spawned), 0);
        check("reset_active_follows_y", 32'(bus.active_count), 1);
        y[1] = 10'd0;
        #1;
        check("reset_active_zero", 32'(bus.active_count), 0);
        rst = 1'b0;

        // 1: first launch after the 20-frame gap, held exactly one frame
        bus.enable  = 1'b1;
        bus.density = 8'd255;
        gap_then_fire("t1");
        check("t1_one_note", 32'(bus.notes_spawned), 1);
        frame(1'b0, f);
        check("t1_spawn_held_one_frame", 32'(bus.spawn), 0);

        // 2: density 0 never fires and parks in ARMED
        do_reset();
        bus.density = 8'd0;
        for (int k = 0; k < 500; k++) frame(1'b1, f);
        check("t2_no_notes", 32'(bus.notes_spawned), 0);
        check("t2_no_spawn", 32'(bus.spawn), 0);
        bus.density = 8'd255;
        f = 1'b0;
        for (int k = 0; k < 8 && !f; k++) frame(1'b1, f);
        check("t2_armed_fires_at_once", 32'(bus.notes_spawned), 1);

        // 3: candidate lane 4 busy, lane 0 busy -> wrap scan lands on lane 1
        do_reset();
        bus.density = 8'd0;
        y[4] = 10'd100;
        y[0] = 10'd100;
        for (int k = 0; k < 20; k++) frame(1'b0, f);
        for (int k = 0; k < 300 && !(lfsr_m[2:0] == 3'd4 && lfsr_m[15:8] != 8'hFF); k++)
            frame(1'b0, f);
        check("t3_active", 32'(bus.active_count), 2);
        bus.density = 8'd255;
        frame(1'b1, f);
        check("t3_wrap_pick", 32'(bus.spawn), 32'b00010);

        // 4: three lanes busy blocks launches until one lane returns to 0
        y[0] = 10'd100; y[1] = 10'd100; y[2] = 10'd100; y[3] = 10'd0; y[4] = 10'd0;
        #1;
        check("t4_active_cap", 32'(bus.active_count), 3);
        for (int k = 0; k < 40; k++) frame(1'b1, f);
        check("t4_no_launch_at_cap", 32'(bus.notes_spawned), 1);
        y[1] = 10'd0;
        f = 1'b0;
        for (int k = 0; k < 8 && !f; k++) frame(1'b1, f);
        check("t4_launch_after_free", 32'(bus.notes_spawned), 2);

        // 5a: enable drop in FIRE clears spawn, keeps count, re-enable restarts full gap
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        check("t5_spawn_cleared_on_disable", 32'(bus.spawn), 0);
        check("t5_notes_kept_on_disable", 32'(bus.notes_spawned), 2);
        for (int k = 0; k < 3; k++) frame(1'b0, f);
        bus.enable = 1'b1;
        gap_then_fire("t5a");

        // 5b: reset in FIRE
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_spawn_cleared_on_reset", 32'(bus.spawn), 0);
        check("t5_notes_cleared_on_reset", 32'(bus.notes_spawned), 0);
        do_reset();
        gap_then_fire("t5b");
        check("t5b_one_note", 32'(bus.notes_spawned), 1);

        // 6: closed loop against sprite models
        sb_on = 1'b0;
        for (int i = 0; i < 5; i++) y[i] = 10'd0;
        do_reset();
        bus.density = 8'd160;
        loop_mode   = 1'b1;
        for (int k = 0; k < 5000; k++) frame(1'b0, f);
        bus.density = 8'd0;
        for (int k = 0; k < 2; k++) frame(1'b0, f);
        check("t6_notes_eq_launches", 32'(bus.notes_spawned), 32'(launches));
        check("t6_some_launches", 32'(launches >= 50), 1);

        check("sb_drained", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
